// File: rtl/burst_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_ram_pkg
// Description : Shared FSM state type and parameter defaults for burst_ram.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAT    = 2'd1,
        RBURST = 2'd2,
        WBURST = 2'd3
    } state_t;

    localparam int c_def_data_w     = 32;
    localparam int c_def_addr_w     = 16;
    localparam int c_def_line_words = 4;
    localparam int c_def_latency    = 4;

endpackage : burst_ram_pkg
`default_nettype wire

// File: rtl/burst_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : burst_ram_array
// Description : Single-port word storage, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int ADDR_W = c_def_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    // Storage is deliberately never reset; only the read register is.
    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : burst_ram_array
`default_nettype wire

// File: rtl/burst_ram.sv
`default_nettype none
// ============================================================================
// Module      : burst_ram
// Description : Line-burst RAM with fixed access latency. Define
//               BURST_RAM_CRITICAL_WORD_FIRST_EN to start bursts at the
//               requested word and wrap within the line.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DATA_W     = c_def_data_w,
    parameter int ADDR_W     = c_def_addr_w,
    parameter int LINE_WORDS = c_def_line_words,
    parameter int LATENCY    = c_def_latency
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              done
);

    localparam int                     c_line_bits = $clog2(LINE_WORDS);
    localparam logic [3:0]             c_latency   = 4'(LATENCY);
    localparam logic [c_line_bits-1:0] c_last_beat = '1;
    localparam logic [c_line_bits-1:0] c_beat_one  = c_line_bits'(1);

    state_t                          r_state;
    logic                            r_we;
    logic [ADDR_W-c_line_bits-1:0]   r_line;
    logic [c_line_bits-1:0]          r_offset;
    logic [c_line_bits-1:0]          r_beat;
    logic [3:0]                      r_lat_cnt;
    logic                            r_req_ready;
    logic                            r_wready;
    logic                            r_rvalid;
    logic                            r_rlast;
    logic                            r_done;

    logic [c_line_bits-1:0]          w_req_offset;
    logic [c_line_bits-1:0]          w_word;
    logic [ADDR_W-1:0]               w_beat_addr;
    logic                            w_accept;
    logic                            w_last;
    logic                            w_arr_we;
    logic                            w_arr_re;

`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
    assign w_req_offset = req_addr[c_line_bits-1:0];
`else
    logic w_unused_offset;
    assign w_req_offset    = '0;
    assign w_unused_offset = ^req_addr[c_line_bits-1:0];
`endif

    // Word index wraps naturally within the line, so bursts never cross it.
    assign w_word      = r_offset + r_beat;
    assign w_beat_addr = {r_line, w_word};
    assign w_accept    = req_valid && r_req_ready;
    assign w_last      = (r_beat == c_last_beat);
    assign w_arr_we    = (r_state == WBURST) && wvalid;
    assign w_arr_re    = (r_state == RBURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_line      <= '0;
            r_offset    <= '0;
            r_beat      <= '0;
            r_lat_cnt   <= '0;
            r_req_ready <= 1'b1;
            r_wready    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_line      <= req_addr[ADDR_W-1:c_line_bits];
                        r_offset    <= w_req_offset;
                        r_beat      <= '0;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state  <= req_we ? WBURST : RBURST;
                            r_wready <= req_we;
                        end else begin
                            r_state   <= LAT;
                            r_lat_cnt <= c_latency;
                        end
                    end
                end
                LAT: begin
                    if (r_lat_cnt == 4'd1) begin
                        r_state   <= r_we ? WBURST : RBURST;
                        r_wready  <= r_we;
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                RBURST: begin
                    // The array registers the read, so these flags line up
                    // with the beat issued on this edge.
                    r_rvalid <= 1'b1;
                    r_beat   <= r_beat + c_beat_one;
                    if (w_last) begin
                        r_rlast     <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                WBURST: begin
                    if (wvalid) begin
                        r_beat <= r_beat + c_beat_one;
                        if (w_last) begin
                            r_wready    <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                            r_req_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_wready    <= 1'b0;
                end
            endcase
        end
    end

    burst_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_beat_addr),
        .i_wdata (wdata),
        .o_rdata (rdata)
    );

    assign req_ready = r_req_ready;
    assign wready    = r_wready;
    assign rvalid    = r_rvalid;
    assign rlast     = r_rlast;
    assign done      = r_done;

endmodule : burst_ram
`default_nettype wire

// File: tb/tb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_ram
// Description : Directed self-checking bench: LATENCY=4 instance plus a
//               LATENCY=0 instance for back-to-back bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        done;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_we = 1'b0;
    logic [7:0]  z_req_addr = '0;
    logic [31:0] z_wdata = '0;
    logic        z_wvalid = 1'b0;
    logic        z_wready;
    logic [31:0] z_rdata;
    logic        z_rvalid;
    logic        z_rlast;
    logic        z_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    burst_ram #(.DATA_W(32), .ADDR_W(16), .LINE_WORDS(4), .LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .done(done)
    );

    burst_ram #(.DATA_W(32), .ADDR_W(8), .LINE_WORDS(4), .LATENCY(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .wdata(z_wdata), .wvalid(z_wvalid), .wready(z_wready),
        .rdata(z_rdata), .rvalid(z_rvalid), .rlast(z_rlast), .done(z_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({rvalid, rlast, done, wready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", {rvalid, rlast, done, wready});
        end
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got=%h exp=00000000", rdata);
        end
        n_checks++;
        if ({req_ready, z_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_req_ready got=%b exp=11", {req_ready, z_req_ready});
        end
    endtask

    task automatic test_write_line(input logic [15:0] addr, input logic [31:0] d0,
                                   input int stall);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_req_ready got=%b exp=1", req_ready);
        end
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (wready !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_latency_wready cycle=%0d got=%b exp=0", c, wready);
            end
            step();
        end
        n_checks++;
        if (wready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_wready_cycle5 got=%b exp=1", wready);
        end
        for (int b = 0; b < 4; b++) begin
            wvalid = 1'b1;
            wdata  = d0 + 32'(b);
            step();
            if (b == 0) begin
                wvalid = 1'b0;
                wdata  = 32'hDEAD_BEEF;
                for (int s = 0; s < stall; s++) begin
                    n_checks++;
                    if ({wready, done} !== 2'b10) begin
                        n_fail++;
                        $display("FAIL wr_stall s=%0d wready_done got=%b exp=10", s, {wready, done});
                    end
                    step();
                end
            end
            if (b < 3) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_done_early beat=%0d got=%b exp=0", b, done);
                end
            end
        end
        wvalid = 1'b0;
        n_checks++;
        if ({done, wready, req_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL wr_done got=%b exp=101", {done, wready, req_ready});
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_read_line(input logic [15:0] addr, input logic [127:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        step();
        req_valid = 1'b0;
        // Stray write beats while not in a write burst must be ignored.
        wvalid = 1'b1;
        wdata  = 32'h0BAD_0BAD;
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if ({rvalid, wready} !== 2'b00) begin
                n_fail++;
                $display("FAIL rd_latency cycle=%0d rvalid_wready got=%b exp=00", c, {rvalid, wready});
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp[32*k +: 32]) begin
                n_fail++;
                $display("FAIL rd_beat addr=%h k=%0d got=%b/%h exp=1/%h",
                         addr, k, rvalid, rdata, exp[32*k +: 32]);
            end
            n_checks++;
            if ({rlast, done} !== {2{k == 3}}) begin
                n_fail++;
                $display("FAIL rd_last_done k=%0d got=%b exp=%b", k, {rlast, done}, {2{k == 3}});
            end
            if (k == 3) begin
                n_checks++;
                if (req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_ready_at_done got=%b exp=1", req_ready);
                end
            end
            step();
        end
        wvalid = 1'b0;
        n_checks++;
        if ({rvalid, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_after got=%b exp=00", {rvalid, done});
        end
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hB1) begin
            n_fail++;
            $display("FAIL rst_pre_beat got=%b/%h exp=1/000000b1", rvalid, rdata);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rvalid, rlast, done, wready} !== 4'b0000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async got=%b/%h exp=0000/00000000", {rvalid, rlast, done, wready}, rdata);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready got=%b exp=1", req_ready);
        end
        step();
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_rvalid got=%b exp=0", rvalid);
        end
        test_read_line(16'h0010, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    endtask

    task automatic test_zero_latency_write(input logic [7:0] addr, input logic [31:0] d0);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = addr;
        step();
        z_req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (z_wready !== 1'b1) begin
                n_fail++;
                $display("FAIL z_wr_wready beat=%0d got=%b exp=1", b, z_wready);
            end
            z_wvalid = 1'b1;
            z_wdata  = d0 + 32'(b);
            step();
        end
        z_wvalid = 1'b0;
        n_checks++;
        if (z_done !== 1'b1) begin
            n_fail++;
            $display("FAIL z_wr_done got=%b exp=1", z_done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int          beats;
        int          m;
        int          bi;
        logic        exp_v;
        logic [31:0] exp_d;
        beats = 0;
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 8'h04;
        n_checks++;
        if (z_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready got=%b exp=1", z_req_ready);
        end
        for (int c = 1; c <= 15; c++) begin
            step();
            m     = c % 5;
            bi    = (c - 1) / 5;
            exp_v = (m != 1);
            exp_d = ((bi == 1) ? 32'hC0 : 32'hD0) + 32'((m + 3) % 5);
            n_checks++;
            if (z_rvalid !== exp_v || (exp_v && z_rdata !== exp_d)) begin
                n_fail++;
                $display("FAIL b2b_beat cycle=%0d got=%b/%h exp=%b/%h", c, z_rvalid, z_rdata, exp_v, exp_d);
            end
            n_checks++;
            if ({z_done, z_rlast, z_req_ready} !== {3{m == 0}}) begin
                n_fail++;
                $display("FAIL b2b_done cycle=%0d got=%b exp=%b", c, {z_done, z_rlast, z_req_ready}, {3{m == 0}});
            end
            if (z_rvalid === 1'b1) beats++;
            if (m == 0) begin
                z_req_addr = (bi == 0) ? 8'h00 : 8'h04;
                if (c == 15) z_req_valid = 1'b0;
            end
        end
        n_checks++;
        if (beats !== 12) begin
            n_fail++;
            $display("FAIL b2b_beat_count got=%0d exp=12", beats);
        end
        step();
        n_checks++;
        if (z_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop got=%b exp=0", z_rvalid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_line(16'h0010, 32'hA0, 0);
`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
        test_read_line(16'h0012, {32'hA1, 32'hA0, 32'hA3, 32'hA2});
`else
        test_read_line(16'h0012, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
`endif
        test_write_line(16'h0020, 32'hB0, 3);
        test_read_line(16'h0020, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        test_reset_mid_read();
        test_zero_latency_write(8'h00, 32'hC0);
        test_zero_latency_write(8'h04, 32'hD0);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_burst_ram
`default_nettype wire
